// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, early exit on first differing digit.
// Unsigned or two's-complement per operation; start/busy/done handshake with held result flags.
module seq_magnitude_comparator #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 2,
  localparam int NCHUNK = WIDTH / DIGIT,
  localparam int CW     = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0]    LAST = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_n;
  logic [WIDTH-1:0] ra, rb, ra_n, rb_n;
  logic [CW-1:0]    idx, idx_n, cycles_n;
  logic             done_n, gt_n, eq_n, lt_n;
  logic [DIGIT-1:0] ca, cb;

  // Captured operands shift left each cycle, so the active digit is always at the top.
  assign ca   = ra[WIDTH-1 -: DIGIT];
  assign cb   = rb[WIDTH-1 -: DIGIT];
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      idx    <= '0;
      done   <= 1'b0;
      gt     <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      cycles <= '0;
    end else begin
      state  <= state_n;
      ra     <= ra_n;
      rb     <= rb_n;
      idx    <= idx_n;
      done   <= done_n;
      gt     <= gt_n;
      eq     <= eq_n;
      lt     <= lt_n;
      cycles <= cycles_n;
    end
  end

  always_comb begin
    state_n  = state;
    ra_n     = ra;
    rb_n     = rb;
    idx_n    = idx;
    done_n   = 1'b0;
    gt_n     = gt;
    eq_n     = eq;
    lt_n     = lt;
    cycles_n = cycles;
    case (state)
      IDLE: begin
        if (start) begin
          // Flipping both MSBs maps two's-complement order onto unsigned order.
          ra_n    = a ^ (signed_mode ? MSB : '0);
          rb_n    = b ^ (signed_mode ? MSB : '0);
          idx_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if ((ca != cb) || (idx == LAST)) begin
          gt_n     = (ca > cb);
          eq_n     = (ca == cb);
          lt_n     = (ca < cb);
          cycles_n = idx + CW'(1);
          done_n   = 1'b1;
          state_n  = IDLE;
        end else begin
          idx_n = idx + CW'(1);
          ra_n  = ra << DIGIT;
          rb_n  = rb << DIGIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator: 8/2 and 16/4 instances checked against an arithmetic model.
module tb_seq_magnitude_comparator;

  typedef struct {
    logic gt;
    logic eq;
    logic lt;
    int   cyc;
    int   t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, gt8, eq8, lt8;
  logic [2:0]  cyc8;
  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, gt16, eq16, lt16;
  logic [2:0]  cyc16;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q8[$];
  exp_t q16[$];

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8), .cycles(cyc8)
  );

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .gt(gt16), .eq(eq16), .lt(lt16), .cycles(cyc16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: first differing digit found by integer shifts, order by signed/unsigned integer compare.
  function automatic exp_t model(input int w, input int d, input logic [15:0] a, input logic [15:0] b,
                                 input bit s, input int base);
    exp_t e;
    int   n, k, va, vb;
    bit   found;
    n = w / d;
    k = n;
    found = 0;
    for (int j = 1; j <= n; j++) begin
      if (!found && ((a >> (w - j * d)) != (b >> (w - j * d)))) begin
        k = j;
        found = 1;
      end
    end
    va = int'(a);
    vb = int'(b);
    if (s && a[w-1]) va = va - (1 << w);
    if (s && b[w-1]) vb = vb - (1 << w);
    e.gt  = (va > vb);
    e.eq  = (va == vb);
    e.lt  = (va < vb);
    e.cyc = k;
    e.t   = base + 1 + k;
    return e;
  endfunction

  // Called just after an edge; start is sampled at the following edge.
  task automatic start_op(input int w, input logic [15:0] a, input logic [15:0] b, input bit s, input bit push);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = s; start8 = 1'b1;
      if (push) q8.push_back(model(8, 2, {8'h00, a[7:0]}, {8'h00, b[7:0]}, s, cyc));
    end else begin
      a16 = a; b16 = b; sm16 = s; start16 = 1'b1;
      if (push) q16.push_back(model(16, 4, a, b, s, cyc));
    end
    @(posedge clk); #1;
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_idle(input int w);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #2;
      if (w == 8) ok = (q8.size() == 0) && !busy8;
      else        ok = (q16.size() == 0) && !busy16;
    end
    if (!ok) chk("wait_idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done8 && busy8) chk("done8_with_busy", 32'd1, 32'd0);
      if (done8) begin
        if (q8.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q8.pop_front();
          chk("flags8", {29'd0, gt8, eq8, lt8}, {29'd0, e.gt, e.eq, e.lt});
          chk("cycles8", {29'd0, cyc8}, 32'(e.cyc));
          chk("latency8", 32'(cyc), 32'(e.t));
        end
      end
      if (done16 && busy16) chk("done16_with_busy", 32'd1, 32'd0);
      if (done16) begin
        if (q16.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q16.pop_front();
          chk("flags16", {29'd0, gt16, eq16, lt16}, {29'd0, e.gt, e.eq, e.lt});
          chk("cycles16", {29'd0, cyc16}, 32'(e.cyc));
          chk("latency16", 32'(cyc), 32'(e.t));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset8_outputs", {26'd0, busy8, done8, gt8, eq8, lt8, cyc8 != 3'd0}, 32'd0);
    chk("reset16_outputs", {26'd0, busy16, done16, gt16, eq16, lt16, cyc16 != 3'd0}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    start_op(8, 16'h00A5, 16'h00A5, 0, 1); wait_idle(8);
    start_op(8, 16'h00C0, 16'h0040, 0, 1); wait_idle(8);
    start_op(8, 16'h00C0, 16'h0040, 1, 1); wait_idle(8);

    // Restart and operand changes during RUN must not disturb the compare in flight
    start_op(8, 16'h0012, 16'h0013, 0, 1);
    chk("busy_after_start", {31'd0, busy8}, 32'd1);
    a8 = 8'hFF; b8 = 8'h00; sm8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_idle(8);
    chk("flags_held_idle", {29'd0, gt8, eq8, lt8}, 32'd1);

    // Reset mid-RUN aborts with no done
    start_op(8, 16'h0000, 16'h0001, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_outputs", {26'd0, busy8, done8, gt8, eq8, lt8, cyc8 != 3'd0}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    start_op(8, 16'h00FF, 16'h0000, 1, 1); wait_idle(8);

    // Start accepted in the done cycle; old result held until the new done
    start_op(8, 16'h00C0, 16'h0040, 0, 1);
    @(posedge clk); #1;
    chk("done_cycle_seen", {31'd0, done8}, 32'd1);
    start_op(8, 16'h007F, 16'h0080, 1, 1);
    chk("b2b_busy", {31'd0, busy8}, 32'd1);
    chk("gt_held_during_run", {29'd0, gt8, eq8, lt8}, 32'd4);
    wait_idle(8);

    start_op(16, 16'h8001, 16'h8001, 0, 1); wait_idle(16);
    start_op(16, 16'h8001, 16'h8001, 1, 1); wait_idle(16);

    // Random compares; equal high digits made likely so every exit point is exercised
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : (ra ^ 16'(1 << $urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom);
      if (i % 2 == 0) begin
        start_op(8, {8'h00, ra[7:0]}, {8'h00, rb[7:0]}, 1'($urandom), 1);
        wait_idle(8);
      end else begin
        start_op(16, ra, rb, 1'($urandom), 1);
        wait_idle(16);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q16_drained", 32'(q16.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
